// File: rtl/hangman_datapath.sv
// Hangman game datapath: word ROM, LFSR word pick, guess latch, guessed mask, miss counter, win/lose flags.
// Optional display scanner enabled by HANGMAN_SCAN_EN (default build ties disp_sel/disp_char to 0).
module hangman_datapath #(
  parameter int NUM_WORDS = 8,
  parameter int MAX_TRIES = 7,
  parameter int SCAN_DIV  = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_char,
  input  logic       en_input_char,
  input  logic       en_word_index,
  input  logic [2:0] s_guessed_letters,
  input  logic       en_guessed_letters,
  input  logic       s_tries,
  input  logic       en_tries,
  input  logic       s_win,
  input  logic       en_win,
  input  logic       s_lose,
  input  logic       en_lose,
  output logic [4:0] input_char_eq_word,
  output logic       guessed_letters_is_done,
  output logic       tries_eq_7,
  output logic [4:0] guessed,
  output logic [2:0] tries,
  output logic       win,
  output logic       lose,
  output logic [2:0] disp_sel,
  output logic [7:0] disp_char
);

  localparam logic [2:0] IDX_MASK  = 3'(NUM_WORDS - 1);
  localparam logic [2:0] TRIES_MAX = 3'(MAX_TRIES);
  localparam logic [2:0] TRIES_FIN = 3'(MAX_TRIES - 1);

  if (SCAN_DIV < 2 || NUM_WORDS < 2 || NUM_WORDS > 8 || MAX_TRIES < 1 || MAX_TRIES > 7) begin : g_bad_param
    $error("hangman_datapath: illegal parameter value");
  end

  function automatic logic [39:0] rom_word(input logic [2:0] idx);
    case (idx)
      3'd0:    return "APPLE";
      3'd1:    return "BRAVE";
      3'd2:    return "CHORD";
      3'd3:    return "DELTA";
      3'd4:    return "EAGLE";
      3'd5:    return "FLAME";
      3'd6:    return "GRAPE";
      default: return "HOUSE";
    endcase
  endfunction

  logic [5:0] lfsr_q, lfsr_d;
  logic [2:0] word_idx_q, word_idx_d;
  logic [7:0] guess_q, guess_d;
  logic [4:0] guessed_q, guessed_d;
  logic [2:0] tries_q, tries_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;
  logic [4:0] set_mask;
  logic [39:0] word_w;
  logic [7:0] letter [5];

  always_comb begin
    word_w = rom_word(word_idx_q);
    for (int k = 0; k < 5; k++) begin
      letter[k]             = word_w[39-8*k -: 8];
      input_char_eq_word[k] = (guess_q == letter[k]) && !guessed_q[k];
    end
  end

  always_comb begin
    lfsr_d     = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[0]};
    word_idx_d = en_word_index ? (lfsr_q[2:0] & IDX_MASK) : word_idx_q;
    guess_d    = en_input_char ? in_char : guess_q;

    // Only codes 1..5 set a bit; 6 and 7 fall through as no-ops.
    set_mask = '0;
    if (en_guessed_letters && s_guessed_letters >= 3'd1 && s_guessed_letters <= 3'd5)
      set_mask = 5'b00001 << (s_guessed_letters - 3'd1);
    if (en_guessed_letters && s_guessed_letters == 3'd0)
      guessed_d = '0;
    else
      guessed_d = guessed_q | set_mask;

    tries_d = tries_q;
    win_d   = en_win  ? s_win  : win_q;
    lose_d  = en_lose ? s_lose : lose_q;
    // A tries clear is a new game and overrides any same-cycle win/lose write.
    if (en_tries) begin
      if (!s_tries) begin
        tries_d = '0;
        win_d   = 1'b0;
        lose_d  = 1'b0;
      end else if (tries_q < TRIES_MAX) begin
        tries_d = tries_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q     <= 6'b000001;
      word_idx_q <= '0;
      guess_q    <= '0;
      guessed_q  <= '0;
      tries_q    <= '0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      word_idx_q <= word_idx_d;
      guess_q    <= guess_d;
      guessed_q  <= guessed_d;
      tries_q    <= tries_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
    end
  end

  assign guessed_letters_is_done = &(guessed_q | set_mask);
  assign tries_eq_7 = (tries_q == TRIES_FIN);
  assign guessed    = guessed_q;
  assign tries      = tries_q;
  assign win        = win_q;
  assign lose       = lose_q;

`ifdef HANGMAN_SCAN_EN
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       disp_sel_q, disp_sel_d;

  always_comb begin
    div_d      = div_q + 1'b1;
    disp_sel_d = disp_sel_q;
    if (div_q == DIV_LAST) begin
      div_d      = '0;
      disp_sel_d = (disp_sel_q == 3'd4) ? 3'd0 : disp_sel_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= '0;
      disp_sel_q <= '0;
    end else begin
      div_q      <= div_d;
      disp_sel_q <= disp_sel_d;
    end
  end

  // Mask is cleared in reset, so the display shows '_' while reset is held.
  assign disp_sel  = disp_sel_q;
  assign disp_char = guessed_q[disp_sel_q] ? letter[disp_sel_q] : 8'h5F;
`else
  assign disp_sel  = 3'd0;
  assign disp_char = 8'h00;
`endif

endmodule

// File: tb/tb_hangman_datapath.sv
// Scoreboard bench for hangman_datapath: driver pushes expected outputs, negedge monitor pops and compares.
module tb_hangman_datapath;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_char;
  logic       en_input_char, en_word_index;
  logic [2:0] s_guessed_letters;
  logic       en_guessed_letters, s_tries, en_tries, s_win, en_win, s_lose, en_lose;
  logic [4:0] input_char_eq_word;
  logic       guessed_letters_is_done, tries_eq_7;
  logic [4:0] guessed;
  logic [2:0] tries;
  logic       win, lose;
  logic [2:0] disp_sel;
  logic [7:0] disp_char;

  hangman_datapath #(.NUM_WORDS(8), .MAX_TRIES(7), .SCAN_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_char(in_char), .en_input_char(en_input_char),
    .en_word_index(en_word_index), .s_guessed_letters(s_guessed_letters),
    .en_guessed_letters(en_guessed_letters), .s_tries(s_tries), .en_tries(en_tries),
    .s_win(s_win), .en_win(en_win), .s_lose(s_lose), .en_lose(en_lose),
    .input_char_eq_word(input_char_eq_word), .guessed_letters_is_done(guessed_letters_is_done),
    .tries_eq_7(tries_eq_7), .guessed(guessed), .tries(tries), .win(win), .lose(lose),
    .disp_sel(disp_sel), .disp_char(disp_char)
  );

  always #5 clk = ~clk;

`ifdef HANGMAN_SCAN_EN
  localparam logic [7:0] IDLE_CHAR = 8'h5F;
`else
  localparam logic [7:0] IDLE_CHAR = 8'h00;
`endif

  typedef enum int {K_EQ, K_DONE, K_T7, K_GUESSED, K_TRIES, K_WIN, K_LOSE, K_SEL, K_CHAR} kind_e;
  typedef struct {
    kind_e      kind;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [5:0] lfsr_m;

  // Reference LFSR, used only to pick the cycle on which a wanted word index is loaded.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) lfsr_m <= 6'b000001;
    else          lfsr_m <= {lfsr_m[4:0], lfsr_m[5] ^ lfsr_m[0]};

  function automatic logic [7:0] actual(input kind_e k);
    case (k)
      K_EQ:      return {3'b000, input_char_eq_word};
      K_DONE:    return {7'd0, guessed_letters_is_done};
      K_T7:      return {7'd0, tries_eq_7};
      K_GUESSED: return {3'b000, guessed};
      K_TRIES:   return {5'd0, tries};
      K_WIN:     return {7'd0, win};
      K_LOSE:    return {7'd0, lose};
      K_SEL:     return {5'd0, disp_sel};
      default:   return disp_char;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t       e;
      logic [7:0] a;
      e = sb.pop_front();
      a = actual(e.kind);
      n_tests++;
      if (a !== e.exp) begin
        n_fail++;
        $display("FAIL %s at %0t: got %h, expected %h", e.kind.name(), $time, a, e.exp);
      end
    end
  end

  task automatic expect_val(input kind_e k, input logic [7:0] v);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [2:0] w);
    int n;
    n = 0;
    while (lfsr_m[2:0] != w && n < 100) begin
      step();
      n++;
    end
    if (lfsr_m[2:0] != w) begin
      n_tests++;
      n_fail++;
      $display("FAIL load_word: lfsr never reached index %0d", w);
    end
    en_word_index = 1'b1;
    step();
    en_word_index = 1'b0;
  endtask

  initial begin
    in_char = 8'h00; en_input_char = 0; en_word_index = 0;
    s_guessed_letters = 3'd0; en_guessed_letters = 0;
    s_tries = 0; en_tries = 0; s_win = 0; en_win = 0; s_lose = 0; en_lose = 0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    expect_val(K_GUESSED, 8'h00); expect_val(K_TRIES, 8'h00); expect_val(K_WIN, 8'h00);
    expect_val(K_LOSE, 8'h00);    expect_val(K_EQ, 8'h00);    expect_val(K_DONE, 8'h00);
    expect_val(K_T7, 8'h00);      expect_val(K_SEL, 8'h00);   expect_val(K_CHAR, IDLE_CHAR);
    @(negedge clk);
    #2 reset_n = 1'b1;

    // First edge after release loads index 1: BRAVE.
    load_word(3'd1);
    in_char = "A"; en_input_char = 1;
    expect_val(K_EQ, 8'h00);
    step();
    en_input_char = 0;
    expect_val(K_EQ, 8'h04);
    s_guessed_letters = 3'd3; en_guessed_letters = 1;
    expect_val(K_DONE, 8'h00); expect_val(K_GUESSED, 8'h00);
    step();
    en_guessed_letters = 0;
    expect_val(K_GUESSED, 8'h04); expect_val(K_EQ, 8'h00);
    step();
    // Latch and compare in the same cycle: compare still sees the old guess.
    in_char = "R"; en_input_char = 1;
    expect_val(K_EQ, 8'h00);
    step();
    en_input_char = 0;
    expect_val(K_EQ, 8'h02);
    for (int i = 0; i < 3; i++) begin
      s_guessed_letters = (i == 0) ? 3'd1 : (i == 1) ? 3'd2 : 3'd4;
      en_guessed_letters = 1;
      step();
    end
    en_guessed_letters = 0; s_guessed_letters = 3'd5;
    expect_val(K_GUESSED, 8'h0F); expect_val(K_DONE, 8'h00);
    step();
    en_guessed_letters = 1;
    expect_val(K_DONE, 8'h01); expect_val(K_GUESSED, 8'h0F);
    step();
    en_guessed_letters = 0;
    expect_val(K_GUESSED, 8'h1F); expect_val(K_DONE, 8'h01); expect_val(K_EQ, 8'h00);
    s_guessed_letters = 3'd6; en_guessed_letters = 1;
    step();
    en_guessed_letters = 0;
    expect_val(K_GUESSED, 8'h1F);
    s_guessed_letters = 3'd0; en_guessed_letters = 1;
    step();
    en_guessed_letters = 0;
    expect_val(K_GUESSED, 8'h00); expect_val(K_EQ, 8'h02);

`ifdef HANGMAN_SCAN_EN
    s_guessed_letters = 3'd2; en_guessed_letters = 1;
    step();
    en_guessed_letters = 0;
    expect_val(K_GUESSED, 8'h02);
    begin
      int         n;
      logic [2:0] prev;
      n = 0;
      prev = disp_sel;
      step();
      while (!(prev == 3'd4 && disp_sel == 3'd0) && n < 40) begin
        prev = disp_sel;
        step();
        n++;
      end
      if (n >= 40) begin
        n_tests++;
        n_fail++;
        $display("FAIL scan_sync: disp_sel never wrapped 4->0");
      end
    end
    for (int i = 0; i < 25; i++) begin
      expect_val(K_SEL, 8'((i / 4) % 5));
      expect_val(K_CHAR, (((i / 4) % 5) == 1) ? 8'h52 : 8'h5F);
      step();
    end
`else
    for (int i = 0; i < 3; i++) begin
      expect_val(K_SEL, 8'h00); expect_val(K_CHAR, 8'h00);
      step();
    end
`endif

    // APPLE: duplicate 'P' needs one guess per occurrence.
    s_guessed_letters = 3'd0; en_guessed_letters = 1;
    step();
    en_guessed_letters = 0;
    load_word(3'd0);
    in_char = "P"; en_input_char = 1;
    step();
    en_input_char = 0;
    expect_val(K_EQ, 8'h06);
    s_guessed_letters = 3'd2; en_guessed_letters = 1;
    step();
    en_guessed_letters = 0;
    expect_val(K_EQ, 8'h04);
    s_guessed_letters = 3'd3; en_guessed_letters = 1;
    step();
    en_guessed_letters = 0;
    expect_val(K_EQ, 8'h00); expect_val(K_GUESSED, 8'h06);

    // Miss counter: saturates at MAX_TRIES, tries_eq_7 flags the final miss.
    s_tries = 0; en_tries = 1;
    step();
    s_tries = 1;
    expect_val(K_TRIES, 8'h00); expect_val(K_T7, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      step();
      expect_val(K_TRIES, 8'((i > 7) ? 7 : i));
      expect_val(K_T7, (i == 6) ? 8'h01 : 8'h00);
    end
    en_tries = 0;
    s_win = 1; en_win = 1; s_lose = 1; en_lose = 1;
    step();
    en_win = 0; en_lose = 0;
    expect_val(K_WIN, 8'h01); expect_val(K_LOSE, 8'h01); expect_val(K_TRIES, 8'h07);
    s_tries = 0; en_tries = 1; en_win = 1; en_lose = 1;
    step();
    en_tries = 0; en_win = 0; en_lose = 0;
    expect_val(K_TRIES, 8'h00); expect_val(K_WIN, 8'h00); expect_val(K_LOSE, 8'h00);

    // Mid-game asynchronous reset.
    s_tries = 1; en_tries = 1;
    step();
    step();
    en_tries = 0;
    expect_val(K_TRIES, 8'h02); expect_val(K_GUESSED, 8'h06);
    step();
    #2 reset_n = 1'b0;
    #1;
    expect_val(K_TRIES, 8'h00); expect_val(K_GUESSED, 8'h00); expect_val(K_EQ, 8'h00);
    expect_val(K_CHAR, IDLE_CHAR);
    @(negedge clk);
    #2 reset_n = 1'b1;
    step();
    step();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
